// File: rtl/math_accum_dump_48.sv
// Block accumulate-and-dump for 49-bit adder sums: sums len samples (or up to a flush),
// then emits a rounded, right-shifted, 48-bit saturated result as a one-cycle pulse.
module math_accum_dump_48 #(
    parameter int CNT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [48:0]          din,
    input  logic                 din_valid,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 flush,
    output logic [47:0]          dout,
    output logic                 dout_valid,
    output logic                 dout_sat
);

    localparam int AW = 49 + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic signed [AW:0] HALF = $signed(({{AW{1'b0}}, 1'b1} << SHIFT) >> 1);
    localparam logic signed [AW:0] MAXV = $signed({{(AW-46){1'b0}}, {47{1'b1}}});
    localparam logic signed [AW:0] MINV = $signed({{(AW-46){1'b1}}, {47{1'b0}}});

    typedef enum logic {IDLE, ACCUM} state_t;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] v);
        logic signed [AW:0] t;
        t = $signed({v[AW-1], v}) + HALF;
        return t >>> SHIFT;
    endfunction

    // Returns {sat_flag, value[47:0]}.
    function automatic logic [48:0] saturate(input logic signed [AW:0] v);
        if (v > MAXV) begin
            return {1'b1, MAXV[47:0]};
        end else if (v < MINV) begin
            return {1'b1, MINV[47:0]};
        end else begin
            return {1'b0, v[47:0]};
        end
    endfunction

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [47:0]            dout_q, dout_d;
    logic                   sat_q, sat_d;
    logic                   vld_q, vld_d;

    logic signed [AW-1:0]   din_ext;
    logic signed [AW-1:0]   sum;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic                   dump;
    logic signed [AW:0]     rs;
    logic [48:0]            sv;

    assign din_ext = $signed({{CNT_WIDTH{din[48]}}, din});
    assign len_eff = (len == '0) ? ONE : len;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dout_d  = dout_q;
        sat_d   = sat_q;
        vld_d   = 1'b0;
        dump    = 1'b0;
        sum     = acc_q;

        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        len_d = len_eff;
                        sum   = din_ext;
                        cnt_d = ONE;
                        if (len_eff == ONE || flush) begin
                            dump = 1'b1;
                        end else begin
                            state_d = ACCUM;
                            acc_d   = din_ext;
                        end
                    end
                end
                ACCUM: begin
                    if (din_valid) begin
                        sum   = acc_q + din_ext;
                        cnt_d = cnt_q + ONE;
                    end
                    acc_d = sum;
                    // The block length is the one latched at block start, not the live port.
                    if ((din_valid && (cnt_q + ONE) == len_q) || flush) begin
                        dump = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rs = round_shift(sum);
        sv = saturate(rs);

        if (dump) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            dout_d  = sv[47:0];
            sat_d   = sv[48];
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= ONE;
            dout_q  <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            sat_q   <= sat_d;
            vld_q   <= vld_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign dout_sat   = sat_q;

endmodule

// File: tb/tb_math_accum_dump_48.sv
// Scoreboard bench for math_accum_dump_48: one instance with SHIFT=0 and one with SHIFT=2.
module tb_math_accum_dump_48;

    typedef struct {
        logic signed [47:0] val;
        logic               sat;
        int                 cyc;
    } exp_t;

    localparam logic signed [48:0] PMAX = 49'sh0_7FFF_FFFF_FFFF;
    localparam logic signed [48:0] NMIN = -49'sh0_8000_0000_0000;
    localparam logic signed [47:0] OMAX = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [47:0] OMIN = 48'sh8000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic ena0, dv0, fl0, ena2, dv2, fl2;
    logic [48:0] din0, din2;
    logic [15:0] len0, len2;
    logic [47:0] dout0, dout2;
    logic dvo0, sat0, dvo2, sat2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    math_accum_dump_48 #(.CNT_WIDTH(16), .SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena0), .din(din0), .din_valid(dv0), .len(len0),
        .flush(fl0), .dout(dout0), .dout_valid(dvo0), .dout_sat(sat0));

    math_accum_dump_48 #(.CNT_WIDTH(16), .SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .ena(ena2), .din(din2), .din_valid(dv2), .len(len2),
        .flush(fl2), .dout(dout2), .dout_valid(dvo2), .dout_sat(sat2));

    task automatic drv0(input logic signed [48:0] d, input logic v, input logic f,
                        input logic [15:0] l, input logic e);
        @(negedge clk);
        din0 = d; dv0 = v; fl0 = f; len0 = l; ena0 = e;
    endtask

    task automatic drv2(input logic signed [48:0] d, input logic v, input logic [15:0] l);
        @(negedge clk);
        din2 = d; dv2 = v; fl2 = 1'b0; len2 = l; ena2 = 1'b1;
    endtask

    task automatic exp0(input logic signed [47:0] v, input logic s);
        q0.push_back('{v, s, cyc + 1});
    endtask

    task automatic exp2(input logic signed [47:0] v, input logic s);
        q2.push_back('{v, s, cyc + 1});
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, $signed(act), $signed(req));
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1; dv0 = 1'b0; fl0 = 1'b0; dv2 = 1'b0; fl2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_dout0", dout0, 48'd0);
        check("rst_vld0", {47'd0, dvo0}, 48'd0);
        check("rst_sat0", {47'd0, sat0}, 48'd0);
        check("rst_dout2", dout2, 48'd0);
    endtask

    always @(negedge clk) begin
        if (dvo0) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL u0_unexpected_pulse: got dout=%0d sat=%0b, required no pulse",
                         $signed(dout0), sat0);
            end else begin
                e0 = q0.pop_front();
                if (dout0 !== e0.val || sat0 !== e0.sat || cyc != e0.cyc) begin
                    fails++;
                    $display("FAIL u0_dump: got dout=%0d sat=%0b cyc=%0d, required dout=%0d sat=%0b cyc=%0d",
                             $signed(dout0), sat0, cyc, e0.val, e0.sat, e0.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (dvo2) begin
            tests++;
            if (q2.size() == 0) begin
                fails++;
                $display("FAIL u2_unexpected_pulse: got dout=%0d sat=%0b, required no pulse",
                         $signed(dout2), sat2);
            end else begin
                e2 = q2.pop_front();
                if (dout2 !== e2.val || sat2 !== e2.sat || cyc != e2.cyc) begin
                    fails++;
                    $display("FAIL u2_dump: got dout=%0d sat=%0b cyc=%0d, required dout=%0d sat=%0b cyc=%0d",
                             $signed(dout2), sat2, cyc, e2.val, e2.sat, e2.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ena0 = 1'b1; dv0 = 1'b0; fl0 = 1'b0; din0 = '0; len0 = 16'd1;
        ena2 = 1'b1; dv2 = 1'b0; fl2 = 1'b0; din2 = '0; len2 = 16'd1;
        repeat (2) @(negedge clk);
        do_rst();

        // Basic block of four
        drv0(1, 1, 0, 4, 1); drv0(2, 1, 0, 4, 1); drv0(3, 1, 0, 4, 1);
        drv0(4, 1, 0, 4, 1); exp0(10, 0);
        drv0(0, 0, 0, 4, 1);
        // Flush on the second sample of a len=3 block, then a clean block
        drv0(5, 1, 0, 3, 1); drv0(7, 1, 1, 3, 1); exp0(12, 0);
        drv0(1, 1, 0, 3, 1); drv0(1, 1, 0, 3, 1); drv0(1, 1, 0, 3, 1); exp0(3, 0);
        // Flush coinciding with the final sample
        drv0(4, 1, 0, 2, 1); drv0(6, 1, 1, 2, 1); exp0(10, 0);
        // Saturation edges
        drv0(PMAX, 1, 0, 2, 1); drv0(PMAX, 1, 0, 2, 1); exp0(OMAX, 1);
        drv0(NMIN, 1, 0, 2, 1); drv0(NMIN, 1, 0, 2, 1); exp0(OMIN, 1);
        drv0(PMAX, 1, 0, 2, 1); drv0(0, 1, 0, 2, 1); exp0(OMAX, 0);
        drv0(0, 0, 0, 2, 1);
        // Clock enable gaps must neither accept samples nor pulse
        drv0(10, 1, 0, 4, 1); drv0(20, 1, 0, 4, 1); drv0(30, 1, 0, 4, 1);
        for (int i = 0; i < 5; i++) drv0(1000, 1, 1, 4, 0);
        drv0(40, 1, 0, 4, 1); exp0(100, 0);
        drv0(0, 0, 0, 4, 1);
        // Partial block discarded by reset
        drv0(2, 1, 0, 4, 1); drv0(2, 1, 0, 4, 1);
        do_rst();
        drv0(1, 1, 0, 4, 1); drv0(1, 1, 0, 4, 1); drv0(1, 1, 0, 4, 1);
        drv0(1, 1, 0, 4, 1); exp0(4, 0);
        // len=0 behaves as 1
        drv0(9, 1, 0, 0, 1); exp0(9, 0);
        drv0(9, 1, 0, 0, 1); exp0(9, 0);
        // len change mid-block is ignored
        drv0(1, 1, 0, 3, 1); drv0(2, 1, 0, 1, 1); drv0(3, 1, 0, 1, 1); exp0(6, 0);
        // Flush in IDLE: no action without a sample, single-sample dump with one
        drv0(0, 0, 1, 5, 1);
        drv0(7, 1, 1, 5, 1); exp0(7, 0);
        // Back-to-back blocks at full throughput
        drv0(1, 1, 0, 2, 1); drv0(2, 1, 0, 2, 1); exp0(3, 0);
        drv0(3, 1, 0, 2, 1); drv0(4, 1, 0, 2, 1); exp0(7, 0);
        // Flush in ACCUM with no sample that cycle
        drv0(8, 1, 0, 5, 1); drv0(0, 0, 1, 5, 1); exp0(8, 0);
        // Negative sum
        drv0(-5, 1, 0, 3, 1); drv0(-6, 1, 0, 3, 1); drv0(2, 1, 0, 3, 1); exp0(-9, 0);
        drv0(0, 0, 0, 3, 1);

        // SHIFT=2 rounding, half-up
        drv2(6, 1, 1); exp2(2, 0);
        drv2(-6, 1, 1); exp2(-1, 0);
        drv2(5, 1, 1); exp2(1, 0);
        drv2(-2, 1, 1); exp2(0, 0);
        drv2(10, 1, 1); exp2(3, 0);
        drv2(1, 1, 1); exp2(0, 0);
        drv2(0, 0, 1);

        repeat (5) @(negedge clk);
        check("u0_pending", 48'(q0.size()), 48'd0);
        check("u2_pending", 48'(q2.size()), 48'd0);
        check("u2_hold", dout2, 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/math_accum_dump_48.md
MATH_ACCUM_DUMP_48 -- requirements
Module: math_accum_dump_48

Interface
REQ-001 The module SHALL have parameter CNT_WIDTH, default 16, giving the width of the block-length input.
REQ-002 The module SHALL have parameter SHIFT, default 0, range 0..16, giving the output right-shift applied before saturation.
REQ-003 The module SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port ena  input  1  active-high clock enable; when low, all state and outputs hold and nothing is accepted.
REQ-006 The module SHALL have port din  input  49  signed sample, which is the 49-bit registered sum of the upstream 48-bit adder.
REQ-007 The module SHALL have port din_valid  input  1  sample qualifier, aligned to the adder's output latency by the instantiating logic.
REQ-008 The module SHALL have port len  input  CNT_WIDTH  samples per dump; the value 0 is treated as 1.
REQ-009 The module SHALL have port flush  input  1  forces an early dump of the partial block.
REQ-010 The module SHALL have port dout  output  48  signed, shifted and saturated dump value, registered.
REQ-011 The module SHALL have port dout_valid  output  1  one-cycle pulse marking a new dout.
REQ-012 The module SHALL have port dout_sat  output  1  set together with dout_valid when saturation occurred.

Function
REQ-013 Internal accumulator: signed, 49+CNT_WIDTH bits; SHALL never wrap for any legal len.
REQ-014 States: IDLE (no partial block) and ACCUM (partial block open); a dump is an action, not a state.
REQ-015 Accepted sample: ena=1 and din_valid=1; no other cycle alters the accumulator or the sample counter.
REQ-016 IDLE + accepted sample: latch len (0 becomes 1); acc = sign-extended din; count = 1; go to ACCUM, unless latched len is 1, in which case dump.
REQ-017 ACCUM + accepted sample: acc += din; count += 1; dump when count reaches the latched len.
REQ-018 len changes during ACCUM SHALL NOT affect the open block.
REQ-019 Dump: result = the acc value including the current sample; arithmetic right shift by SHIFT with round-half-up (add 2^(SHIFT-1) before shifting when SHIFT>0); saturate to [-2^47, 2^47-1]; return to IDLE; acc cleared.
REQ-020 dout, dout_sat and dout_valid SHALL be registered with latency 1: dout_valid=1 on the cycle after the clock edge on which the dump condition was sampled.
REQ-021 dout and dout_sat SHALL hold their values until the next dump.
REQ-022 dout_valid SHALL be low on every other cycle, including all cycles with ena=0.
REQ-023 flush=1 with ena=1 in ACCUM: dump, including din if din_valid is high on the same cycle.
REQ-024 flush=1 in IDLE with din_valid=1: single-sample dump; flush=1 in IDLE with din_valid=0: no action, no dout_valid.
REQ-025 flush coinciding with the final sample of a block SHALL produce exactly one dump.
REQ-026 A dump followed by a sample on the next cycle SHALL start a new block with no lost samples; full throughput is one sample per cycle.
REQ-027 dout_sat=1 iff the rounded, shifted value lay outside the 48-bit signed range.

Reset
REQ-028 rst=1 at a clock edge SHALL force: state IDLE, acc=0, count=0, dout=0, dout_valid=0, dout_sat=0, latched len=1.
REQ-029 rst SHALL have priority over ena, din_valid and flush.
REQ-030 A partial block open when reset is asserted SHALL be discarded with no dump.

Verification
REQ-031 len=4, SHIFT=0, din=1,2,3,4 on consecutive valid cycles -> one dout_valid pulse 1 cycle after the 4th sample, dout=10, dout_sat=0.
REQ-032 len=3, samples 5 then a flush coinciding with sample 7 -> dout=12 exactly once; the next block starts cleanly with acc from 0.
REQ-033 len=2, SHIFT=0, din=2^47-1 twice -> dout=2^47-1, dout_sat=1; with din=-2^47 twice -> dout=-2^47, dout_sat=1.
REQ-034 SHIFT=2, len=1, din=6 then din=-6 -> dout=2, then dout=-1 (round-half-up); dout_sat=0.
REQ-035 len=4, three samples accepted, then ena=0 for 5 cycles, then one more sample -> no pulse while ena=0; dump value equals the sum of all 4 samples.
REQ-036 len=4, two samples then rst for 1 cycle, then samples 1,1,1,1 -> no dump from the partial block; dout=4; len=0 with a single sample 9 -> dout=9 on every sample.
